// File: rtl/c3lib_cdc_pkg.sv
// Shared types and helpers for the c3lib clock-domain-crossing handshake blocks.
package c3lib_cdc_pkg;

    typedef enum logic {
        HS_IDLE     = 1'b0,
        HS_WAIT_ACK = 1'b1
    } hs_tx_state_e;

    localparam int SYNC_STAGES_MAX = 4;

    // A disabled timeout (0) still needs a 1-bit counter so the ports stay legal.
    function automatic int tmo_cnt_w(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/c3lib_sync_sr_behav.sv
// Single-bit synchronizer chain with synchronous active-high reset.
module c3lib_sync_sr_behav
    import c3lib_cdc_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Out-of-range depths are clamped to the supported 2..SYNC_STAGES_MAX window.
    localparam int STAGES = (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                            (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) chain <= {STAGES{RESET_VAL}};
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/c3lib_cdc_hs_tx.sv
// Launch side of a toggle-handshake CDC: captures a word, flips the request
// toggle and waits for the synchronized ack toggle to match it.
module c3lib_cdc_hs_tx
    import c3lib_cdc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_req_tgl,
    input  logic             ack_tgl_async,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    input  logic             err_clr
);

    localparam int CW = tmo_cnt_w(TIMEOUT_CYC);
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYC);
    // Flag is raised on the edge where the counter reaches TIMEOUT_CYC.
    localparam logic [CW-1:0] TMO_SET = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    hs_tx_state_e  state;
    logic          ack_sync;
    logic [CW-1:0] cnt;
    logic          tmo_hit;

    c3lib_sync_sr_behav #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_tgl_async),
        .q   (ack_sync)
    );

    assign src_ready = (state == HS_IDLE) & ~rst;
    assign busy      = (state == HS_WAIT_ACK);
    assign tmo_hit   = (TIMEOUT_CYC > 0) && busy && (cnt >= TMO_SET);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HS_IDLE;
            tx_data    <= '0;
            tx_req_tgl <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                HS_IDLE: begin
                    if (src_valid && src_ready) begin
                        tx_data    <= src_data;
                        tx_req_tgl <= ~tx_req_tgl;
                        cnt        <= '0;
                        state      <= HS_WAIT_ACK;
                    end
                end
                HS_WAIT_ACK: begin
                    if (cnt != TMO_MAX) cnt <= cnt + 1'b1;
                    // A late ack still completes the transfer even after a timeout.
                    if (ack_sync == tx_req_tgl) begin
                        state <= HS_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= HS_IDLE;
            endcase
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)          err_timeout <= 1'b0;
        else if (tmo_hit) err_timeout <= 1'b1;
        else if (err_clr) err_timeout <= 1'b0;
    end

endmodule

// File: tb/tb_c3lib_cdc_hs_tx.sv
// Directed bench for c3lib_cdc_hs_tx (WIDTH=8, SYNC_STAGES=2, TIMEOUT_CYC=16).
module tb_c3lib_cdc_hs_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic [7:0] tx_data;
    logic       tx_req_tgl;
    logic       ack_tgl_async;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic       err_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    c3lib_cdc_hs_tx #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_ready     (src_ready),
        .tx_data       (tx_data),
        .tx_req_tgl    (tx_req_tgl),
        .ack_tgl_async (ack_tgl_async),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout),
        .err_clr       (err_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept w, expect request toggle t, echo the ack dly cycles after accept,
    // then expect done SYNC_STAGES+1 cycles after the ack edge.
    task automatic xfer(input logic [7:0] w, input logic t, input int dly);
        src_valid = 1'b1;
        src_data  = w;
        step();
        chk("acc_tgl",  {31'd0, tx_req_tgl}, {31'd0, t});
        chk("acc_data", {24'd0, tx_data}, {24'd0, w});
        chk("acc_busy", {31'd0, busy}, 32'd1);
        chk("acc_rdy",  {31'd0, src_ready}, 32'd0);
        src_data = ~w;
        for (int i = 1; i < dly; i++) step();
        ack_tgl_async = t;
        step();
        step();
        chk("pre_done", {31'd0, done}, 32'd0);
        chk("hold_data", {24'd0, tx_data}, {24'd0, w});
        step();
        chk("done",      {31'd0, done}, 32'd1);
        chk("done_rdy",  {31'd0, src_ready}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_data", {24'd0, tx_data}, {24'd0, w});
        src_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; src_valid = 1'b0; src_data = 8'h00;
        ack_tgl_async = 1'b0; err_clr = 1'b0;
        repeat (3) step();

        // Reset release
        rst = 1'b0;
        #1;
        chk("rst_rdy",  {31'd0, src_ready}, 32'd1);
        chk("rst_tgl",  {31'd0, tx_req_tgl}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_err",  {31'd0, err_timeout}, 32'd0);
        step();

        // Basic transfer
        xfer(8'hA5, 1'b1, 9);
        step();
        chk("basic_done_1cyc", {31'd0, done}, 32'd0);

        // Clean reset, then back-to-back with a 5-cycle echo
        rst = 1'b1; ack_tgl_async = 1'b0;
        step();
        rst = 1'b0;
        xfer(8'h01, 1'b1, 5);
        xfer(8'h02, 1'b0, 5);
        xfer(8'h03, 1'b1, 5);
        step();
        chk("b2b_idle_done", {31'd0, done}, 32'd0);
        chk("b2b_last_data", {24'd0, tx_data}, 32'h03);

        // Timeout: ack withheld, err_clr coincident with the set cycle
        src_valid = 1'b1; src_data = 8'h44;
        step();
        src_valid = 1'b0;
        chk("tmo_tgl", {31'd0, tx_req_tgl}, 32'd0);
        for (int i = 1; i < 15; i++) step();
        chk("tmo_not_yet", {31'd0, err_timeout}, 32'd0);
        step();
        chk("tmo_pre", {31'd0, err_timeout}, 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("tmo_set_wins", {31'd0, err_timeout}, 32'd1);
        chk("tmo_busy", {31'd0, busy}, 32'd1);
        repeat (3) step();
        ack_tgl_async = 1'b0;
        step();
        step();
        chk("tmo_pre_done", {31'd0, done}, 32'd0);
        step();
        chk("tmo_late_done", {31'd0, done}, 32'd1);
        chk("tmo_sticky", {31'd0, err_timeout}, 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("tmo_clr", {31'd0, err_timeout}, 32'd0);

        // Reset mid-transfer, with src_valid held during reset
        src_valid = 1'b1; src_data = 8'h77;
        step();
        src_valid = 1'b0;
        chk("mid_tgl", {31'd0, tx_req_tgl}, 32'd1);
        repeat (17) step();
        chk("mid_err", {31'd0, err_timeout}, 32'd1);
        rst = 1'b1; ack_tgl_async = 1'b0; src_valid = 1'b1; src_data = 8'h99;
        #1;
        chk("mid_rdy_in_rst", {31'd0, src_ready}, 32'd0);
        step();
        chk("mid_rst_tgl",  {31'd0, tx_req_tgl}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_err",  {31'd0, err_timeout}, 32'd0);
        chk("mid_rst_data", {24'd0, tx_data}, 32'd0);
        rst = 1'b0; src_valid = 1'b0;
        #1;
        chk("mid_rel_rdy", {31'd0, src_ready}, 32'd1);
        step();
        xfer(8'h5C, 1'b1, 4);
        step();

        // Spurious ack toggle in IDLE: ignored, next transfer completes at once
        ack_tgl_async = 1'b0;
        repeat (5) step();
        chk("spur_done", {31'd0, done}, 32'd0);
        chk("spur_rdy",  {31'd0, src_ready}, 32'd1);
        chk("spur_tgl",  {31'd0, tx_req_tgl}, 32'd1);
        src_valid = 1'b1; src_data = 8'hC3;
        step();
        src_valid = 1'b0;
        chk("spur_acc_tgl",  {31'd0, tx_req_tgl}, 32'd0);
        chk("spur_acc_busy", {31'd0, busy}, 32'd1);
        chk("spur_acc_done", {31'd0, done}, 32'd0);
        step();
        chk("spur_imm_done", {31'd0, done}, 32'd1);
        chk("spur_imm_data", {24'd0, tx_data}, 32'hC3);
        step();
        chk("spur_done_clr", {31'd0, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
